// File: rtl/mudi_unit.sv
// EX-stage multiply/divide unit: architectural HI/LO plus signed/unsigned MULT/DIV with fixed-latency busy window.
// Latency: MULT_CYCLES / DIV_CYCLES edges from start to HI/LO update; MTHI/MTLO write on the start edge.
// Backpressure: busy stalls the hazard unit; starts while busy are dropped. Optional MUDI_MADD_EN adds MADD/MSUB ops.
module mudi_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hl_sel,
    output logic             busy,
    output logic [WIDTH-1:0] mudi_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = 6;
    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MUDI_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi_q, lo_q, res_hi, res_lo;
    logic               res_wr;
`ifdef MUDI_MADD_EN
    logic               acc_en, acc_sub, nx_acc_en, nx_acc_sub;
`endif

    logic                 signed_div, sa, sb;
    logic [WIDTH-1:0]     div_n, div_d, uq, ur, q, r;
    logic [2*WIDTH-1:0]   prod_s, prod_u;
    logic                 nx_run, nx_wr;
    logic [CNT_W-1:0]     nx_cyc;
    logic [2*WIDTH-1:0]   nx_res;

    always_comb begin
        sa         = a[WIDTH-1];
        sb         = b[WIDTH-1];
        signed_div = (op == OP_DIV);
        // One shared magnitude divider; the most-negative / -1 case falls out as LO=a, HI=0.
        div_n = (signed_div && sa) ? -a : a;
        div_d = (signed_div && sb) ? -b : b;
        if (b == '0)
            div_d = {{(WIDTH-1){1'b0}}, 1'b1};
        uq = div_n / div_d;
        ur = div_n % div_d;
        q  = (signed_div && (sa ^ sb)) ? -uq : uq;
        r  = (signed_div && sa) ? -ur : ur;
        prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

        nx_run = 1'b0;
        nx_wr  = 1'b1;
        nx_cyc = CNT_W'(MULT_CYCLES);
        nx_res = prod_s;
`ifdef MUDI_MADD_EN
        nx_acc_en  = 1'b0;
        nx_acc_sub = 1'b0;
`endif
        case (op)
            OP_MULT:  nx_run = 1'b1;
            OP_MULTU: begin nx_run = 1'b1; nx_res = prod_u; end
            OP_DIV, OP_DIVU: begin
                nx_run = 1'b1;
                nx_cyc = CNT_W'(DIV_CYCLES);
                nx_res = {r, q};
                nx_wr  = (b != '0);
            end
`ifdef MUDI_MADD_EN
            OP_MADD, OP_MSUB: begin
                nx_run = 1'b1; nx_acc_en = 1'b1; nx_acc_sub = (op == OP_MSUB);
            end
            OP_MADDU, OP_MSUBU: begin
                nx_run = 1'b1; nx_acc_en = 1'b1; nx_acc_sub = (op == OP_MSUBU);
                nx_res = prod_u;
            end
`endif
            default: nx_run = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_wr <= 1'b0;
`ifdef MUDI_MADD_EN
            acc_en  <= 1'b0;
            acc_sub <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        if (nx_run) begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            cnt    <= nx_cyc;
                            {res_hi, res_lo} <= nx_res;
                            res_wr <= nx_wr;
`ifdef MUDI_MADD_EN
                            acc_en  <= nx_acc_en;
                            acc_sub <= nx_acc_sub;
`endif
                        end else if (op == OP_MTHI) begin
                            hi_q <= a;
                        end else if (op == OP_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        // Accumulate reads HI/LO at completion, not at issue.
`ifdef MUDI_MADD_EN
                        if (acc_en)
                            {hi_q, lo_q} <= acc_sub ? ({hi_q, lo_q} - {res_hi, res_lo})
                                                    : ({hi_q, lo_q} + {res_hi, res_lo});
                        else
`endif
                        if (res_wr) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign mudi_out = hl_sel ? hi_q : lo_q;
endmodule

// File: tb/tb_mudi_unit.sv
// Directed-vector bench for mudi_unit with hand-computed HI/LO results and busy-window lengths.
module tb_mudi_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0, b = '0;
    logic        flush = 1'b0;
    logic        hl_sel = 1'b0;
    logic        busy;
    logic [31:0] mudi_out, hi, lo;
    int          n_chk = 0, n_pass = 0;
    int          cyc;

    mudi_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hl_sel(hl_sel), .busy(busy), .mudi_out(mudi_out),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles after issue, bounded so a stuck busy cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
        issue(o, x, y);
        wait_idle(n);
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_out", mudi_out, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // MULT -2*3
        issue(4'd0, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy_old_out", mudi_out, 0);
        wait_idle(cyc);
        check("mult_cycles", cyc, 5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, cyc);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        run_op(4'd2, -32'sd7, 32'd2, cyc);
        check("div_cycles", cyc, 10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(4'd3, 32'd7, 32'd2, cyc);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        // Back-to-back MTHI / MTLO
        @(negedge clk);
        start = 1'b1; op = 4'd4; a = 32'h1234_5678;
        @(negedge clk);
        check("mthi_busy", busy, 0);
        op = 4'd5; a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_busy", busy, 0);
        hl_sel = 1'b1; #1;
        check("mf_hi", mudi_out, 32'h1234_5678);
        hl_sel = 1'b0; #1;
        check("mf_lo", mudi_out, 32'h9ABC_DEF0);

        // Divide by zero leaves HI/LO alone
        issue(4'd4, 32'd5, 32'd0);
        issue(4'd5, 32'd6, 32'd0);
        run_op(4'd2, 32'd100, 32'd0, cyc);
        check("div0_cycles", cyc, 10);
        check("div0_hi", hi, 32'd5);
        check("div0_lo", lo, 32'd6);

        run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        // Flush in busy cycle 3
        issue(4'd0, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        repeat (8) @(negedge clk);
        check("flush_hi", hi, 32'd0);
        check("flush_lo", lo, 32'h8000_0000);

        // Flush on the completion edge
        issue(4'd0, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_last_busy", busy, 0);
        check("flush_last_lo", lo, 32'h8000_0000);

        // start+flush on same edge: MT suppressed, MULT not started
        @(negedge clk);
        start = 1'b1; op = 4'd5; a = 32'h0000_AAAA; flush = 1'b1;
        @(negedge clk);
        op = 4'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("sf_busy", busy, 0);
        check("sf_lo", lo, 32'h8000_0000);

        // start while busy is dropped
        issue(4'd0, 32'd2, 32'd3);
        start = 1'b1; op = 4'd1; a = 32'd7; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_idle(cyc);
        check("sb_cycles", cyc + 1, 5);
        check("sb_hilo", {hi, lo}, 64'd6);

        // Async reset mid-DIV
        issue(4'd2, 32'd100, 32'd3);
        @(negedge clk);
        check("ar_busy_pre", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // MADDU (or undefined op 7 without the feature)
        issue(4'd4, 32'd0, 32'd0);
        issue(4'd5, 32'hFFFF_FFFF, 32'd0);
        run_op(4'd7, 32'd1, 32'd1, cyc);
`ifdef MUDI_MADD_EN
        check("maddu_cycles", cyc, 5);
        check("maddu_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        check("op7_cycles", cyc, 0);
        check("op7_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mudi_unit.md
Name: mudi_unit

Overview:
- Parametrised multiply/divide unit for the EX stage, replacing the bare HI/LO read mux.
- Holds the architectural HI/LO registers and runs signed/unsigned multiply and divide with a programmable multi-cycle latency.
- Drives a busy handshake that the hazard unit uses to stall mult/div/mf/mt instructions.
- Provides the HI/LO read value (mudi_out) that is carried down the pipeline to the writeback mux.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- MULT_CYCLES, 5, busy cycles for multiply ops (legal 1..31).
- DIV_CYCLES, 10, busy cycles for divide ops (legal 1..63).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  operation request; sampled on the rising edge
- op  in  4  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6..9 see optional feature
- a  in  WIDTH  operand rs (dividend / multiplicand / mt source)
- b  in  WIDTH  operand rt (divisor / multiplier)
- flush  in  1  cancel the in-flight operation (exception/interrupt at EX)
- hl_sel  in  1  read select: 0=LO, 1=HI
- busy  out  1  operation in flight
- mudi_out  out  WIDTH  combinational read: hl_sel ? HI : LO
- hi  out  WIDTH  HI register (debug/trace)
- lo  out  WIDTH  LO register (debug/trace)

Behaviour:
- Reset (async, reset_n=0): HI=0, LO=0, busy=0, cycle counter=0, result/op latches cleared; mudi_out=0.
- States: IDLE, RUN.
- IDLE, start=1, op in 0..3:
  - Latch op, a, b; compute the result into internal res_hi/res_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN. busy=1 from the next cycle.
- IDLE, start=1, op 4/5 (MTHI/MTLO): write a into HI/LO at that edge; no RUN, busy stays 0.
- IDLE, start=1, undefined op: ignored; no state change.
- RUN: counter decrements each edge. On the edge where counter==1:
  - HI<=res_hi, LO<=res_lo, busy<=0, return to IDLE.
  - Latency: start at edge N → busy high for cycles N+1..N+L → new HI/LO visible after edge N+L.
- start while busy=1: ignored. The hazard unit guarantees no issue while busy; the unit does not queue.
- flush=1 in RUN: return to IDLE next edge, busy=0, HI/LO unchanged, result discarded.
- flush=1 in IDLE together with start: flush wins; nothing executes, MT writes are suppressed.
- flush on the same edge as completion (counter==1): flush wins; HI/LO unchanged.
- Arithmetic:
  - MULT: signed 2*WIDTH product; {HI,LO} = a*b.
  - MULTU: unsigned 2*WIDTH product; {HI,LO} = a*b.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned; LO = quotient, HI = remainder.
- Divide by zero (b==0, DIV/DIVU): full DIV_CYCLES busy; HI/LO left unchanged.
- Signed overflow (DIV, a=-2^(WIDTH-1), b=-1): LO=a, HI=0; no trap.
- mudi_out always reflects the current HI/LO registers. During RUN it returns the old values; the hazard unit stalls MFHI/MFLO while busy.

Optional Feature:
- Macro: MUDI_MADD_EN.
- Defined:
  - op 6=MADD, 7=MADDU, 8=MSUB, 9=MSUBU.
  - {HI,LO} <= {HI,LO} ± product, signed/unsigned as for MULT/MULTU, modulo 2^(2*WIDTH).
  - Uses MULT_CYCLES. HI/LO are sampled at completion so that an MT in flight cannot race.
  - flush semantics identical to the base ops.
- Undefined: ops 6..9 are treated as undefined (ignored, busy stays 0). No accumulate adder is synthesised.

Test Plan:
- Reset then MULT: a=0xFFFFFFFE(-2), b=3 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy=0 on the same edge. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=-7, b=2 → after 10 busy cycles LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIVU a=7, b=2 → LO=3, HI=1.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on back-to-back cycles → busy never asserts; hl_sel=1 reads 0x12345678, hl_sel=0 reads 0x9ABCDEF0.
- DIV with b=0 after HI=5, LO=6 → busy for 10 cycles; HI=5, LO=6 afterwards. DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- MULT started, flush asserted in busy cycle 3 → busy=0 next cycle, HI/LO hold old values. Separately, start+flush on the same edge → no execution. Also: start asserted while busy → ignored, result matches the first op only.
- reset_n dropped asynchronously mid-DIV → busy, HI, LO go to 0 immediately, without waiting for a clock edge. With MUDI_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU a=1, b=1 → HI=1, LO=0. Without the macro, op=7 leaves HI/LO unchanged and busy=0.
